// File: rtl/spi_sensor_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_sensor_slave
// Brief   : SPI responder that serves {HDR, hold, TAIL} MSB-first on miso
//           (CPOL=1, ss/sclk oversampled in the clk domain).
// Revision: 1.0 - initial release
// ============================================================================
module spi_sensor_slave #(
  parameter logic [3:0] HDR        = 4'h0,
  parameter logic [3:0] TAIL       = 4'h0,
  parameter logic [7:0] RESET_DATA = 8'h00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ss,
  input  logic       sclk,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       miso,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic        r_ss_s1, r_ss_s2, r_ss_s3;
  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        w_ss_fall, w_ss_rise, w_sclk_rise;

  state_t      r_state, w_state_nxt;
  logic [14:0] r_shift, w_shift_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_miso, w_miso_nxt;
  logic        r_done, w_done_nxt;
  logic        r_abort, w_abort_nxt;

  logic [7:0]  r_hold, r_pend;
  logic        r_pend_vld;
  logic [15:0] w_frame;
  logic        w_ret_idle;

  // ss syncs reset to 0 so a select still held low across reset is not
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_s3   <= 1'b0;
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
    end else begin
      r_ss_s1   <= ss;
      r_ss_s2   <= r_ss_s1;
      r_ss_s3   <= r_ss_s2;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
    end
  end

  assign w_ss_fall   =  r_ss_s3 & ~r_ss_s2;
  assign w_ss_rise   = ~r_ss_s3 &  r_ss_s2;
  assign w_sclk_rise = ~r_sclk_s3 & r_sclk_s2;
  assign w_frame     = {HDR, r_hold, TAIL};

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_miso_nxt  = r_miso;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_ss_fall) begin
          w_shift_nxt = w_frame[14:0];
          w_miso_nxt  = w_frame[15];
          w_cnt_nxt   = 5'd0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A 16th edge coinciding with deselect still counts as completion.
        if (w_sclk_rise && (r_cnt == 5'd15)) begin
          w_cnt_nxt   = 5'd16;
          w_miso_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = w_ss_rise ? ST_IDLE : ST_DONE;
        end else if (w_ss_rise) begin
          w_miso_nxt  = 1'b0;
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_cnt_nxt   = r_cnt + 5'd1;
          w_miso_nxt  = r_shift[14];
          w_shift_nxt = {r_shift[13:0], 1'b0};
        end
      end
      ST_DONE: begin
        w_miso_nxt = 1'b0;
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_miso_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_shift <= 15'd0;
      r_cnt   <= 5'd0;
      r_miso  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_miso  <= w_miso_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign w_ret_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  // A strobe on the return-to-idle cycle is newer than any pending byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold     <= RESET_DATA;
      r_pend     <= 8'h00;
      r_pend_vld <= 1'b0;
    end else if (w_ret_idle) begin
      if (sample_valid) begin
        r_hold     <= sample;
        r_pend_vld <= 1'b0;
      end else if (r_pend_vld) begin
        r_hold     <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end else if (sample_valid) begin
      if ((r_state == ST_IDLE) && !w_ss_fall) begin
        r_hold <= sample;
      end else begin
        r_pend     <= sample;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign miso        = r_miso;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = r_done;
  assign frame_abort = r_abort;

endmodule
`default_nettype wire
